// File: rtl/memory_col_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_col_arbiter
// Purpose  : Sequencer/arbiter in front of a single-port memory column.
//            After reset it sweeps every word to INIT_VAL, then shares the
//            one access port between NUM_REQ requesters using round-robin
//            arbitration (one access per cycle). Read data from the column's
//            1-cycle registered read port is routed back to the requester
//            that issued the read.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            req_valid/we/addr/wdata - per-requester request (packed buses)
//            req_ready            - one-hot grant
//            rsp_valid/rsp_rdata  - one-hot read response + data
//            init_done            - clear sweep finished
//            mem_addr/mem_wr_data/mem_byte_en/mem_rd_data - column port
// Revision : 1.0 - initial release
// ============================================================================
module memory_col_arbiter #(
    parameter int                NUM_REQ  = 4,
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        init_done,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wr_data,
    output logic                        mem_byte_en,
    input  logic [DATA_W-1:0]           mem_rd_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic                r_rd_pending;
    logic [PTR_W-1:0]    r_rd_id;
    logic                r_init_done;

    logic [NUM_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic                w_gnt_any;
    logic                w_gnt_we;
    logic                w_run;

    // Grants are only visible in RUN and never while reset is asserted.
    assign w_run = (r_state == ST_RUN) && !rst;

    // Round-robin search: try candidates rr_ptr, rr_ptr+1, ... (mod NUM_REQ)
    // and take the first valid one. The inner loop keeps every bit select
    // constant so the candidate index never has to be a variable index.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_gnt_any && req_valid[i] &&
                    (i == ((int'(r_rr_ptr) + k) % NUM_REQ))) begin
                    w_gnt_any  = 1'b1;
                    w_gnt_idx  = PTR_W'(i);
                    w_grant[i] = 1'b1;
                end
            end
        end
    end

    assign req_ready = w_run ? w_grant : '0;

    // Memory port mux: the clear sweep owns the port in INIT, the granted
    // requester owns it in RUN.
    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_byte_en = 1'b0;
        w_gnt_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_we = req_we[i];
            end
        end
        if (!rst) begin
            if (r_state == ST_INIT) begin
                mem_addr    = r_init_cnt;
                mem_wr_data = INIT_VAL;
                mem_byte_en = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w_grant[i]) begin
                        mem_addr    = req_addr[i*ADDR_W +: ADDR_W];
                        mem_wr_data = req_wdata[i*DATA_W +: DATA_W];
                        mem_byte_en = req_we[i];
                    end
                end
            end
        end
    end

    // Response strobe is decoded from the registered pending/id pair. It is
    // gated by rst so a read accepted just before reset never responds.
    always_comb begin
        rsp_valid = '0;
        if (!rst && r_rd_pending) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_rd_id == PTR_W'(i)) begin
                    rsp_valid[i] = 1'b1;
                end
            end
        end
    end

    // The column's read data is already registered, so it passes straight
    // through in the cycle after acceptance.
    assign rsp_rdata = mem_rd_data;
    assign init_done = r_init_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_rr_ptr     <= '0;
            r_rd_pending <= 1'b0;
            r_rd_id      <= '0;
            r_init_done  <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt   <= r_init_cnt + 1'b1;
            r_rd_pending <= 1'b0;
            if (r_init_cnt == ADDR_W'(DEPTH - 1)) begin
                r_state     <= ST_RUN;
                r_init_done <= 1'b1;
            end
        end else begin
            r_rd_pending <= w_gnt_any && !w_gnt_we;
            r_rd_id      <= w_gnt_idx;
            if (w_gnt_any) begin
                r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                               : w_gnt_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/memory_col_arbiter.md
Name: memory_col_arbiter

Overview:
- Sequencer/arbiter in front of one 1024x8 memory column; memory_col keeps a single access port with a 1-cycle registered read.
- After reset, clears the whole column to INIT_VAL.
- Then shares the single port between NUM_REQ requesters with round-robin arbitration, one access per cycle.
- Returns read data to the owning requester one cycle after acceptance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, memory address width (binary address).
- DATA_W, 8, memory data width.
- DEPTH, 1024, memory words; must equal 2**ADDR_W.
- INIT_VAL, 8'h00, value written to every word during init.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester access request.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- rsp_valid  output  NUM_REQ  one-hot read response strobe.
- rsp_rdata  output  DATA_W  read data, valid when any rsp_valid bit is set.
- init_done  output  1  high once the clear sweep has completed.
- mem_addr  output  ADDR_W  to the memory column address.
- mem_wr_data  output  DATA_W  to the memory column write data.
- mem_byte_en  output  1  memory write enable.
- mem_rd_data  input  DATA_W  memory registered read data, mem[addr of previous cycle].

Behaviour:
- States: INIT, RUN.
- Reset, synchronous, taking effect at the clock edge:
  - state=INIT, init_cnt=0, rr_ptr=0, rd_pending=0, init_done=0.
- While rst=1: req_ready=0, mem_byte_en=0, rsp_valid=0.
- INIT:
  - mem_addr=init_cnt, mem_wr_data=INIT_VAL, mem_byte_en=1, req_ready=0.
  - init_cnt increments each cycle.
  - At init_cnt==DEPTH-1, next state is RUN and init_done goes to 1 at the same edge.
  - The sweep takes exactly DEPTH cycles after reset release.
  - Requests arriving during INIT are held off, never dropped; the requester keeps valid asserted.
- RUN, arbitration:
  - Combinational round-robin arbitration.
  - Search starts at rr_ptr and proceeds upward, modulo NUM_REQ; the first i with req_valid[i] is granted.
  - req_ready[i]=1 for the granted requester only.
  - req_ready may depend combinationally on req_valid.
- RUN, accepted access:
  - mem_addr=req_addr[g], mem_wr_data=req_wdata[g], mem_byte_en=req_we[g].
  - rr_ptr <= (g+1) mod NUM_REQ.
- RUN, no request: mem_byte_en=0, mem_addr=0, rr_ptr unchanged.
- Read accepted in cycle T:
  - rd_pending<=1 and rd_id<=g.
  - In cycle T+1: rsp_valid[rd_id]=1 and rsp_rdata=mem_rd_data (passthrough).
  - Latency is exactly 1 cycle.
  - Back-to-back reads give back-to-back responses.
- Writes produce no response; they are complete at the accepting edge.
- Same-address write in T, read in T+1: the read returns the new data.
- Read and write to the same address cannot collide in one cycle; there is a single port.
- rsp_rdata is don't-care when rsp_valid==0; the bench must not check it.
- Reset mid-operation:
  - Any pending read response is discarded; rsp_valid stays 0 in the following cycle.
  - rr_ptr returns to 0 and a full INIT sweep reruns.
- init_done stays 1 until the next rst.

Test Plan:
- Init sweep: deassert rst, count cycles.
  - mem_byte_en=1 for exactly 1024 cycles with mem_addr 0..1023 in order.
  - init_done rises after the write to addr 1023.
  - After init, a read of addr 5 returns 8'h00.
- Write/read: requester 1 writes 8'hA5 to addr 10'h3FF, then reads it back.
  - rsp_valid=4'b0010 one cycle after the read is accepted; rsp_rdata=8'hA5.
- Round-robin: all 4 requesters hold valid continuously, reads to addrs 0,1,2,3 preloaded with 8'h10..8'h13.
  - Grants go 0,1,2,3,0 in consecutive cycles.
  - Responses 8'h10..8'h13 follow in order, one cycle late.
- Pointer skip: rr_ptr=1, only requesters 0 and 3 valid.
  - Grant 3, then 0, then 3.
- Held-off during INIT: requester 2 asserts valid at reset release.
  - req_ready[2] stays 0 for 1024 cycles.
  - Grant in the first RUN cycle.
- Reset mid-read: read accepted in cycle T, rst=1 in T+1.
  - No rsp_valid ever appears for that read.
  - INIT restarts at mem_addr 0.
